// File: rtl/core_pkg.sv
// Shared definitions for the memory-access stage: opcodes, funct3 codes, FSM state enum.
// Access size is derived here so store and load paths agree on byte/half/word decoding.
package core_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} ma_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

  // Unsigned byte/half codes exist only for loads; for stores they fall to word.
  function automatic acc_size_t access_size(input logic is_store, input logic [2:0] f3);
    if (f3 == F3_B || (!is_store && f3 == F3_BU)) return SZ_BYTE;
    if (f3 == F3_H || (!is_store && f3 == F3_HU)) return SZ_HALF;
    return SZ_WORD;
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-cache request/response bundle between the memory-access stage (master) and the cache (slave).
interface memory_access_if;
  logic        dcache_req;
  logic        dcache_ready;
  logic        dcache_we;
  logic [31:0] dcache_addr;
  logic [31:0] dcache_wdata;
  logic [3:0]  dcache_be;
  logic        dcache_rvalid;
  logic [31:0] dcache_rdata;

  modport master (
    output dcache_req, dcache_we, dcache_addr, dcache_wdata, dcache_be,
    input  dcache_ready, dcache_rvalid, dcache_rdata
  );

  modport slave (
    input  dcache_req, dcache_we, dcache_addr, dcache_wdata, dcache_be,
    output dcache_ready, dcache_rvalid, dcache_rdata
  );
endinterface

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed byte/half from the raw word and extends it.
module load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b  = rdata[{addr, 3'b000} +: 8];
    sel_h  = addr[1] ? rdata[31:16] : rdata[15:0];
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{sel_b[7]}}, sel_b};
      F3_H:    result = {{16{sel_h[15]}}, sel_h};
      F3_BU:   result = {24'b0, sel_b};
      F3_HU:   result = {16'b0, sel_h};
      F3_W:    result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues one data-cache request per load/store and formats load data.
// Optional macro MISALIGN_TRAP_EN adds a misalign output and skips misaligned half/word accesses.
module memory_access
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [31:0]     alu_out,
  input  logic [31:0]     rs2_data,
  memory_access_if.master dcache,
  output logic [31:0]     dcache_out,
  output logic            done,
  output logic            busy
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  ma_state_t   state;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] load_result;

  logic        is_store;
  logic        is_mem;
  logic        mis;
  acc_size_t   size;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  always_comb begin
    is_store = (opcode == OP_STORE);
    is_mem   = (opcode == OP_LOAD) || is_store;
    size     = access_size(is_store, funct3);
    mis      = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = is_mem && ((size == SZ_HALF && alu_out[0]) ||
                     (size == SZ_WORD && alu_out[1:0] != 2'b00));
`endif
    case (size)
      SZ_BYTE: begin
        be_next    = 4'b0001 << alu_out[1:0];
        wdata_next = {4{rs2_data[7:0]}};
      end
      SZ_HALF: begin
        be_next    = alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{rs2_data[15:0]}};
      end
      default: begin
        be_next    = '1;
        wdata_next = rs2_data;
      end
    endcase
  end

  load_align u_load_align (
    .rdata  (dcache.dcache_rdata),
    .addr   (addr_lo_q),
    .funct3 (funct3_q),
    .result (load_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      is_load_q           <= 1'b0;
      funct3_q            <= '0;
      addr_lo_q           <= '0;
      dcache.dcache_req   <= 1'b0;
      dcache.dcache_we    <= 1'b0;
      dcache.dcache_addr  <= '0;
      dcache.dcache_wdata <= '0;
      dcache.dcache_be    <= '0;
      dcache_out          <= '0;
      done                <= 1'b0;
      busy                <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign            <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            is_load_q <= (opcode == OP_LOAD);
            funct3_q  <= funct3;
            addr_lo_q <= alu_out[1:0];
            // Non-memory ops and trapped misaligned accesses finish without touching the cache.
            if (is_mem && !mis) begin
              state               <= REQ;
              dcache.dcache_req   <= 1'b1;
              dcache.dcache_we    <= is_store;
              dcache.dcache_addr  <= {alu_out[31:2], 2'b00};
              dcache.dcache_be    <= be_next;
              dcache.dcache_wdata <= wdata_next;
            end else begin
              state      <= DONE;
              done       <= 1'b1;
              dcache_out <= '0;
            end
`ifdef MISALIGN_TRAP_EN
            misalign <= mis;
`endif
          end
        end
        REQ: begin
          if (dcache.dcache_ready) begin
            state             <= WAIT;
            dcache.dcache_req <= 1'b0;
          end
        end
        WAIT: begin
          if (dcache.dcache_rvalid) begin
            state      <= DONE;
            done       <= 1'b1;
            dcache_out <= is_load_q ? load_result : '0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          misalign <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: expected load results are queued at start and popped at done.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] alu_out;
  logic [31:0] rs2_data;
  logic [31:0] dcache_out;
  logic        done;
  logic        busy;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  memory_access_if dc ();

  memory_access dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .funct3     (funct3),
    .alu_out    (alu_out),
    .rs2_data   (rs2_data),
    .dcache     (dc),
    .dcache_out (dcache_out),
    .done       (done),
    .busy       (busy)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign   (misalign)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;
  logic [31:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " req"},   32'(dc.dcache_req), 0);
    check({name, " done"},  32'(done), 0);
    check({name, " busy"},  32'(busy), 0);
    check({name, " we"},    32'(dc.dcache_we), 0);
    check({name, " be"},    32'(dc.dcache_be), 0);
    check({name, " out"},   dcache_out, 0);
    check({name, " addr"},  dc.dcache_addr, 0);
    check({name, " wdata"}, dc.dcache_wdata, 0);
  endtask

  // Runs one operation up to the cycle where done is observed; cache responds after ready_delay.
  task automatic do_op(input string name, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                       input int ready_delay, input bit mem, input logic [3:0] exp_be,
                       input bit chk_wdata, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_out, input int exp_lat, input bit poke_start);
    int lat;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    opcode = op; funct3 = f3; alu_out = addr; rs2_data = rs2; start = 1'b1;
    exp_q.push_back(exp_out);
    step();
    lat = 1;
    start = 1'b0; opcode = 7'b0110011; alu_out = '1; rs2_data = '0; funct3 = 3'b111;
    check({name, " req"},  32'(dc.dcache_req), 32'(mem));
    check({name, " busy"}, 32'(busy), 1);
    if (mem) begin
      check({name, " addr"}, dc.dcache_addr, exp_addr);
      check({name, " be"},   32'(dc.dcache_be), 32'(exp_be));
      check({name, " we"},   32'(dc.dcache_we), 32'(op == 7'b0100011));
      if (chk_wdata) check({name, " wdata"}, dc.dcache_wdata, exp_wdata);
      for (int i = 0; i < ready_delay; i++) begin
        if (poke_start && i == 1) begin
          start = 1'b1; opcode = 7'b0000011; alu_out = 32'h0000_0F00; funct3 = 3'b000;
        end
        step();
        lat++;
        start = 1'b0;
        check({name, " req held"},  32'(dc.dcache_req), 1);
        check({name, " addr held"}, dc.dcache_addr, exp_addr);
      end
      dc.dcache_ready = 1'b1;
      step();
      lat++;
      dc.dcache_ready = 1'b0;
      check({name, " req drop"}, 32'(dc.dcache_req), 0);
      check({name, " no early done"}, 32'(done), 0);
      dc.dcache_rdata = rdata; dc.dcache_rvalid = 1'b1;
      step();
      lat++;
      dc.dcache_rvalid = 1'b0; dc.dcache_rdata = 32'h0BAD_0BAD;
    end
    while (!done && lat < 30) begin
      step();
      lat++;
    end
    check({name, " done"},    32'(done), 1);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    if (exp_q.size() > 0) check({name, " out"}, dcache_out, exp_q.pop_front());
  endtask

  task automatic idle_check(input string name, input logic [31:0] exp_out);
    step();
    check({name, " done pulse"}, 32'(done), 0);
    check({name, " idle busy"},  32'(busy), 0);
    check({name, " out held"},   dcache_out, exp_out);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = '0; funct3 = '0; alu_out = '0; rs2_data = '0;
    dc.dcache_ready = 1'b0; dc.dcache_rvalid = 1'b0; dc.dcache_rdata = '0;
    step(); step();
    check_all_zero("reset");
`ifdef MISALIGN_TRAP_EN
    check("reset misalign", 32'(misalign), 0);
`endif
    rst_n = 1'b1;
    step();

    do_op("LB", 7'b0000011, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000,
          0, 1, 4'b1000, 0, 32'h0, 32'hFFFF_FF80, 3, 0);
    idle_check("LB", 32'hFFFF_FF80);

    do_op("ADD", 7'b0110011, 3'b000, 32'h0000_0103, 32'h0, 32'h0,
          0, 0, 4'b0000, 0, 32'h0, 32'h0, 1, 0);
    idle_check("ADD", 32'h0);

    do_op("LH", 7'b0000011, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_7FFF,
          0, 1, 4'b1100, 0, 32'h0, 32'hFFFF_8001, 3, 0);
    idle_check("LH", 32'hFFFF_8001);

    do_op("SH", 7'b0100011, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,
          0, 1, 4'b1100, 1, 32'hABCD_ABCD, 32'h0, 3, 0);
    idle_check("SH", 32'h0);

    do_op("LW stall", 7'b0000011, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF,
          5, 1, 4'b1111, 0, 32'h0, 32'hDEAD_BEEF, 8, 1);
    idle_check("LW stall", 32'hDEAD_BEEF);

    do_op("LBU", 7'b0000011, 3'b100, 32'h0000_0101, 32'h0, 32'h0000_8000,
          0, 1, 4'b0010, 0, 32'h0, 32'h0000_0080, 3, 0);
    idle_check("LBU", 32'h0000_0080);

    do_op("LHU", 7'b0000011, 3'b101, 32'h0000_0100, 32'h0, 32'h8001_F00D,
          0, 1, 4'b0011, 0, 32'h0, 32'h0000_F00D, 3, 0);
    idle_check("LHU", 32'h0000_F00D);

    do_op("SB", 7'b0100011, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0,
          0, 1, 4'b0010, 1, 32'hA5A5_A5A5, 32'h0, 3, 0);
    idle_check("SB", 32'h0);

    do_op("SW", 7'b0100011, 3'b010, 32'h0000_0104, 32'h1122_3344, 32'h0,
          1, 1, 4'b1111, 1, 32'h1122_3344, 32'h0, 4, 0);
    idle_check("SW", 32'h0);

    do_op("L011", 7'b0000011, 3'b011, 32'h0000_0108, 32'h0, 32'hCAFE_F00D,
          0, 1, 4'b1111, 0, 32'h0, 32'hCAFE_F00D, 3, 0);
    idle_check("L011", 32'hCAFE_F00D);

`ifdef MISALIGN_TRAP_EN
    do_op("LW mis", 7'b0000011, 3'b010, 32'h0000_0101, 32'h0, 32'h0,
          0, 0, 4'b0000, 0, 32'h0, 32'h0, 1, 0);
    check("LW mis flag", 32'(misalign), 1);
    idle_check("LW mis", 32'h0);
    check("LW mis flag clear", 32'(misalign), 0);
`else
    do_op("LW unal", 7'b0000011, 3'b010, 32'h0000_0101, 32'h0, 32'h55AA_55AA,
          0, 1, 4'b1111, 0, 32'h0, 32'h55AA_55AA, 3, 0);
    idle_check("LW unal", 32'h55AA_55AA);
`endif

    // Stray handshake strobes while idle must not start anything.
    dc.dcache_ready = 1'b1; dc.dcache_rvalid = 1'b1;
    step();
    dc.dcache_ready = 1'b0; dc.dcache_rvalid = 1'b0;
    check("stray done", 32'(done), 0);
    check("stray busy", 32'(busy), 0);
    check("stray req",  32'(dc.dcache_req), 0);

    // Reset while waiting for the response, then a late rvalid.
    opcode = 7'b0000011; funct3 = 3'b010; alu_out = 32'h0000_0300; rs2_data = 32'h7777_7777;
    start = 1'b1;
    step();
    start = 1'b0;
    dc.dcache_ready = 1'b1;
    step();
    dc.dcache_ready = 1'b0;
    check("rst busy before", 32'(busy), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    dc.dcache_rdata = 32'h1234_5678; dc.dcache_rvalid = 1'b1;
    step();
    dc.dcache_rvalid = 1'b0;
    check_all_zero("rst mid");
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst late done", 32'(done), 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001: Block SHALL have no parameters; data/address width fixed at 32.
REQ-002: clk  in  1  single clock, all state on rising edge.
REQ-003: rst_n  in  1  reset, synchronous, active-low.
REQ-004: start  in  1  one-cycle pulse; opcode/funct3/alu_out/rs2_data valid this cycle.
REQ-005: opcode  in  7  instruction opcode.
REQ-006: funct3  in  3  access width/sign.
REQ-007: alu_out  in  32  effective byte address.
REQ-008: rs2_data  in  32  store data.
REQ-009: dcache_req  out  1  request valid.
REQ-010: dcache_ready  in  1  cache accepts request.
REQ-011: dcache_we  out  1  1=store, 0=load.
REQ-012: dcache_addr  out  32  word address, bits[1:0]=0.
REQ-013: dcache_wdata  out  32  lane-replicated store data.
REQ-014: dcache_be  out  4  byte enables.
REQ-015: dcache_rvalid  in  1  response/ack valid.
REQ-016: dcache_rdata  in  32  raw read word.
REQ-017: dcache_out  out  32  formatted load result, to writeback.
REQ-018: done  out  1  one-cycle completion pulse, to writeback.
REQ-019: busy  out  1  high in any state but IDLE.

Function
REQ-020: FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-021: IDLE + start: opcode 0000011 (LOAD) or 0100011 (STORE) -> REQ, else -> DONE; inputs latched at start.
REQ-022: REQ: dcache_req=1, addr/we/be/wdata held stable; ready sampled high -> WAIT.
REQ-023: WAIT: dcache_req=0; rvalid high -> DONE, loads capture formatted data into dcache_out.
REQ-024: DONE: done=1 exactly one cycle, then IDLE; dcache_out held until next start.
REQ-025: Latency: non-memory op start at cycle N -> done at N+1; memory op with ready at N+1, rvalid at N+2 -> done at N+3.
REQ-026: start while busy SHALL be ignored; rvalid outside WAIT ignored; ready outside REQ ignored.
REQ-027: Loads by funct3: 000 LB sign-ext byte addr[1:0]; 001 LH sign-ext half addr[1]; 010 LW; 100 LBU zero-ext; 101 LHU zero-ext; other codes treated as LW.
REQ-028: Stores: SB be=0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH be=0011<<(2*addr[1]), wdata={2{rs2[15:0]}}; SW/other be=1111, wdata=rs2.
REQ-029: Stores and non-memory ops SHALL set dcache_out=0 at DONE.

Reset
REQ-030: rst_n low at a clock edge -> IDLE; dcache_req, done, busy, dcache_we, dcache_be, dcache_out, dcache_addr, dcache_wdata all 0.
REQ-031: Reset mid-operation SHALL abandon the access with no done pulse; a late rvalid after reset is ignored.

Configuration
REQ-032: Macro MISALIGN_TRAP_EN defined: port misalign (out 1) exists; half with addr[0]=1 or word with addr[1:0]!=0 -> no cache request, go DONE, misalign=1 with done, dcache_out=0; misalign=0 otherwise, and 0 at reset.
REQ-033: MISALIGN_TRAP_EN undefined: no misalign port; half uses addr[1] only, word ignores addr[1:0]; access proceeds normally.

Structure
REQ-034: Shared package core_pkg SHALL hold OP_LOAD, OP_STORE, funct3 codes and the FSM state enum.
REQ-035: Load extraction/extension SHALL be a combinational sub-module load_align (rdata, addr[1:0], funct3 -> 32-bit result).

Verification
REQ-036: ADD opcode 0110011 start -> no dcache_req, done at +1 cycle, dcache_out=0.
REQ-037: LB addr 0x103, rdata 0x80FF_0000, ready immediate, rvalid +1 -> dcache_out 0xFFFF_FF80, done at start+3.
REQ-038: SH addr 0x202, rs2 0x1234_ABCD -> dcache_addr 0x200, be 1100, wdata 0xABCD_ABCD, we=1.
REQ-039: LW with ready held low 5 cycles -> req and addr stable throughout; done only after rvalid; second start during wait ignored.
REQ-040: rst_n low in WAIT, rvalid next cycle -> no done, all outputs 0.
REQ-041: With MISALIGN_TRAP_EN, LW addr 0x101 -> no request, done+misalign at start+1; without it, access to 0x100 with be 1111.
